muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//   Multi-cycle HI/LO multiply/divide unit for the MIPS core. Consumes the rs/rt
//   operands read from the register file; owns the architectural HI and LO registers.
//   Serves MULT/MULTU/DIV/DIVU and MTHI/MTLO. Exposes busy so the control path stalls
//   MFHI/MFLO and new mul/div ops until the result is committed.
// PARAMETERS
//   WIDTH     32   operand width; HI and LO are WIDTH bits each
// PORTS
//   clk        in   1      clock; all state updates on posedge
//   rst        in   1      asynchronous, active-high reset
//   start      in   1      launch op; sampled only when busy=0
//   op         in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a          in   WIDTH  rs operand (dividend / multiplicand)
//   b          in   WIDTH  rt operand (divisor / multiplier)
//   cancel     in   1      abort the in-flight op (exception flush)
//   hi_we      in   1      MTHI: write wd into HI
//   lo_we      in   1      MTLO: write wd into LO
//   wd         in   WIDTH  MTHI/MTLO data
//   busy       out  1      op in flight; HI/LO not yet valid
//   done       out  1      one-cycle pulse: HI/LO committed at the preceding edge
//   hi         out  WIDTH  HI register
//   lo         out  WIDTH  LO register
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; hi=lo=0; busy=0; done=0; datapath regs 0.
//   FSM states: IDLE, MUL, DIV, FIX.
//   - IDLE & start & op[1]=0 -> MUL. IDLE & start & op[1]=1 -> DIV.
//   - MUL -> IDLE after 1 cycle; the edge writes {hi,lo} = a*b.
//     Signed product for MULT, unsigned for MULTU, full 2*WIDTH bits.
//   - DIV: restoring divide on |a|,|b| (raw values for DIVU); one quotient bit per
//     cycle for WIDTH cycles, counter 0..WIDTH-1, then -> FIX.
//   - FIX -> IDLE after 1 cycle; the edge applies signs and writes lo=quotient,
//     hi=remainder.
//   Latency, with start sampled at edge E0:
//   - MULT/MULTU: busy=1 from E0 to E1; HI/LO written at E1; done=1 from E1 to E2.
//   - DIV/DIVU: busy=1 from E0 to E(WIDTH+1); HI/LO written at E(WIDTH+1);
//     done follows for 1 cycle.
//   - Operands a, b, op are captured at E0 and need not be held afterwards.
//   Signed division:
//   - Quotient truncates toward zero; remainder takes the sign of the dividend.
//   - 0x80000000 / -1 gives lo=0x80000000, hi=0.
//   Divide by zero (b=0), both DIV and DIVU:
//   - lo=all-ones, hi=a.
//   - Still takes the full WIDTH+1 cycles; no early exit.
//   busy is combinational from state: busy = (state != IDLE). done is registered.
//   start while busy=1: ignored. There is no queue, and the caller must respect busy.
//   hi_we/lo_we:
//   - Applied at the edge only when state=IDLE and start=0.
//   - When start=1 in IDLE, start wins and the MTHI/MTLO write is dropped.
//   - While busy=1: ignored.
//   - hi_we and lo_we together: both are written with wd.
//   cancel:
//   - While busy=1: the next edge returns to IDLE, hi/lo are unchanged, no done pulse.
//   - cancel with start in IDLE: start is suppressed.
//   - cancel in the FIX or MUL cycle: the commit is suppressed.
//   Reset mid-operation: abandons the op immediately, and hi=lo=0 (not preserved).
//   hi/lo change only on a commit, MTHI/MTLO, or reset.
// TESTING
//   1. MULT a=0xFFFFFFFE(-2), b=3: busy 1 cycle, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done 1 cycle.
//   2. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
//   3. DIV a=-7, b=2: busy exactly 33 cycles, then lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
//      DIVU 7/2 gives lo=3, hi=1.
//   4. DIVU a=0x1234, b=0: lo=0xFFFFFFFF, hi=0x1234 after 33 cycles.
//      DIV 0x80000000 by -1: lo=0x80000000, hi=0.
//   5. Back-to-back and collision cases:
//      - start reasserted while busy: ignored, result unchanged.
//      - MTHI 0xA5A5A5A5 while busy: dropped.
//      - MTLO in IDLE: lo=wd next edge.
//      - start + hi_we in the same cycle: HI write dropped.
//   6. cancel at DIV iteration 10: IDLE next edge, hi/lo keep prior values, no done.
//      rst asserted mid-DIV: busy=0, hi=lo=0 immediately.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle HI/LO multiply/divide unit.
// MULT/MULTU commit in one cycle after launch; DIV/DIVU run a restoring
// divider (one quotient bit per cycle) followed by a sign-fix cycle.
// The unit owns the architectural HI and LO registers and serves MTHI/MTLO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state, state_next;

  // Operands captured at launch; a_reg/b_reg keep the raw values.
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             signed_op;     // MULT / DIV (op[0] = 0)
  logic             a_neg, b_neg;  // operand signs, signed ops only
  logic             b_zero;

  // Restoring-divider state: quo shifts the |dividend| out MSB-first while
  // quotient bits shift in at the bottom; rem holds the partial remainder.
  logic [WIDTH-1:0] quo, rem, dvsr;
  logic [CW-1:0]    count;

  // Launch/handshake decode.
  logic launch;
  logic mt_ok;
  logic commit_mul;
  logic commit_div;

  // Datapath combinational results.
  logic             in_signed;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   rem_shift;
  logic             take;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] quo_step, rem_step;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;

  // A launch needs IDLE, start, and no simultaneous flush.
  always_comb begin
    in_signed = ~op[0];
    launch    = (state == IDLE) && start && !cancel;
    mt_ok     = (state == IDLE) && !start;
    a_abs     = (in_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_abs     = (in_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; cancel pulls any busy state straight back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (launch) begin
          state_next = op[1] ? DIV : MUL;
        end
      end
      MUL: begin
        state_next = IDLE;
      end
      DIV: begin
        if (cancel) begin
          state_next = IDLE;
        end else if (count == CW'(WIDTH - 1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM outputs: busy from state, commit strobes gated by cancel.
  always_comb begin
    busy       = (state != IDLE);
    commit_mul = (state == MUL) && !cancel;
    commit_div = (state == FIX) && !cancel;
  end

  // One restoring step, the sign fix and the full-width product.
  always_comb begin
    rem_shift = {rem, quo[WIDTH-1]};
    take      = (rem_shift >= {1'b0, dvsr});
    // Only used when take=1, where the difference is below 2^WIDTH.
    diff      = rem_shift[WIDTH-1:0] - dvsr;
    quo_step  = {quo[WIDTH-2:0], take};
    rem_step  = take ? diff : rem_shift[WIDTH-1:0];

    q_fix = (a_neg ^ b_neg) ? (~quo + 1'b1) : quo;
    r_fix = a_neg ? (~rem + 1'b1) : rem;

    // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the
    // product are then correct for both signed and unsigned operands.
    a_ext = {{WIDTH{signed_op & a_reg[WIDTH-1]}}, a_reg};
    b_ext = {{WIDTH{signed_op & b_reg[WIDTH-1]}}, b_reg};
    prod  = a_ext * b_ext;
  end

  // Operand capture at launch, then one divider iteration per DIV cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      signed_op <= 1'b0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      b_zero    <= 1'b0;
      quo       <= '0;
      rem       <= '0;
      dvsr      <= '0;
      count     <= '0;
    end else if (launch) begin
      a_reg     <= a;
      b_reg     <= b;
      signed_op <= in_signed;
      a_neg     <= in_signed & a[WIDTH-1];
      b_neg     <= in_signed & b[WIDTH-1];
      b_zero    <= (b == '0);
      quo       <= a_abs;
      rem       <= '0;
      dvsr      <= b_abs;
      count     <= '0;
    end else if (state == DIV) begin
      quo       <= quo_step;
      rem       <= rem_step;
      count     <= count + 1'b1;
    end
  end

  // HI/LO: commits take priority; MTHI/MTLO only in an idle, non-launch cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (commit_mul) begin
      hi <= prod[2*WIDTH-1:WIDTH];
      lo <= prod[WIDTH-1:0];
    end else if (commit_div) begin
      // Divide by zero reports the raw dividend and an all-ones quotient,
      // independent of operand signs.
      if (b_zero) begin
        hi <= a_reg;
        lo <= '1;
      end else begin
        hi <= r_fix;
        lo <= q_fix;
      end
    end else if (mt_ok) begin
      if (hi_we) begin
        hi <= wd;
      end
      if (lo_we) begin
        lo <= wd;
      end
    end
  end

  // done pulses for the cycle after a committing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= commit_mul | commit_div;
    end
  end

endmodule
